// File: rtl/frame_capture_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// frame_capture_ctrl
//  Top-level sequencer for the OV7670 capture path. Waits out camera power-up,
//  kicks the SCCB init in cam_top, retries it on timeout, then gates pixel-BRAM
//  writes on whole-frame boundaries in continuous or snapshot mode.
//
//  Ports
//   i_top_clk      system clock
//   w_rst_btn_db   asynchronous active-low reset (debounced button)
//   i_auto_start   level, permits init once the power-up delay has elapsed
//   o_cam_start    1-cycle pulse to cam_top i_cam_start
//   i_cam_done     level, cam_top init complete
//   i_vsync_async  raw camera VSYNC, asynchronous to i_top_clk
//   i_mode_cont    1 = continuous capture, 0 = snapshot
//   i_snap_req     1-cycle pulse, request one new frame while holding
//   o_cap_en       BRAM write enable, only changes at frame boundaries
//   o_frame_cnt    completed captured frames, wraps
//   o_busy         1 during power-up wait and camera configuration
//   o_init_fail    sticky, init attempts exhausted
//   o_state        current state encoding for debug/LEDs
// -----------------------------------------------------------------------------
module frame_capture_ctrl #(
   parameter int unsigned PWRUP_DELAY_CYC  = 1_000_000,
   parameter int unsigned INIT_TIMEOUT_CYC = 5_000_000,
   parameter int unsigned MAX_RETRIES      = 3,
   parameter int unsigned CNT_W            = 16
) (
   input  logic             i_top_clk,
   input  logic             w_rst_btn_db,
   input  logic             i_auto_start,
   output logic             o_cam_start,
   input  logic             i_cam_done,
   input  logic             i_vsync_async,
   input  logic             i_mode_cont,
   input  logic             i_snap_req,
   output logic             o_cap_en,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic             o_busy,
   output logic             o_init_fail,
   output logic [2:0]       o_state
);

   localparam int unsigned PWR_W = (PWRUP_DELAY_CYC > 0) ? $clog2(PWRUP_DELAY_CYC + 1) : 1;
   localparam int unsigned TO_W  = (INIT_TIMEOUT_CYC > 1) ? $clog2(INIT_TIMEOUT_CYC + 1) : 1;
   localparam int unsigned ATT_W = $clog2(MAX_RETRIES + 1);

   typedef enum logic [2:0] {
      ST_RST_WAIT  = 3'd0,
      ST_CFG_START = 3'd1,
      ST_CFG_WAIT  = 3'd2,
      ST_SYNC      = 3'd3,
      ST_CAPTURE   = 3'd4,
      ST_HOLD      = 3'd5,
      ST_ARM       = 3'd6,
      ST_FAIL      = 3'd7
   } state_t;

   state_t             r_state;
   logic [PWR_W-1:0]   r_pwr_cnt;
   logic [TO_W-1:0]    r_to_cnt;
   logic [ATT_W-1:0]   r_attempt_cnt;
   logic               r_cam_start;
   logic               r_cap_en;
   logic [CNT_W-1:0]   r_frame_cnt;
   logic               r_busy;
   logic               r_init_fail;

   logic               r_vs_meta;
   logic               r_vs_sync;
   logic               r_vs_prev;
   logic               r_vs_rise;

   // VSYNC synchroniser and rising-edge detect; r_vs_rise marks end of frame
   always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
      if (!w_rst_btn_db) begin
         r_vs_meta <= 1'b0;
         r_vs_sync <= 1'b0;
         r_vs_prev <= 1'b0;
         r_vs_rise <= 1'b0;
      end else begin
         r_vs_meta <= i_vsync_async;
         r_vs_sync <= r_vs_meta;
         r_vs_prev <= r_vs_sync;
         r_vs_rise <= r_vs_sync & ~r_vs_prev;
      end
   end

   // Sequencer; outputs are updated on the same edge as the state they describe
   always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
      if (!w_rst_btn_db) begin
         r_state       <= ST_RST_WAIT;
         r_pwr_cnt     <= '0;
         r_to_cnt      <= '0;
         r_attempt_cnt <= '0;
         r_cam_start   <= 1'b0;
         r_cap_en      <= 1'b0;
         r_frame_cnt   <= '0;
         r_busy        <= 1'b1;
         r_init_fail   <= 1'b0;
      end else begin
         r_cam_start <= 1'b0;
         case (r_state)
            ST_RST_WAIT: begin
               if (r_pwr_cnt != PWR_W'(PWRUP_DELAY_CYC)) begin
                  r_pwr_cnt <= r_pwr_cnt + PWR_W'(1);
               end else if (i_auto_start) begin
                  r_state     <= ST_CFG_START;
                  r_cam_start <= 1'b1;
               end
            end

            ST_CFG_START: begin
               r_attempt_cnt <= r_attempt_cnt + ATT_W'(1);
               r_to_cnt      <= '0;
               r_state       <= ST_CFG_WAIT;
            end

            ST_CFG_WAIT: begin
               // done wins over a timeout landing on the same cycle
               if (i_cam_done) begin
                  r_state <= ST_SYNC;
                  r_busy  <= 1'b0;
               end else if (r_to_cnt == TO_W'(INIT_TIMEOUT_CYC - 1)) begin
                  if (r_attempt_cnt == ATT_W'(MAX_RETRIES)) begin
                     r_state     <= ST_FAIL;
                     r_busy      <= 1'b0;
                     r_init_fail <= 1'b1;
                  end else begin
                     r_state     <= ST_CFG_START;
                     r_cam_start <= 1'b1;
                  end
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end

            // partial frame in flight after init is discarded
            ST_SYNC: begin
               if (r_vs_rise) begin
                  r_state  <= ST_CAPTURE;
                  r_cap_en <= 1'b1;
               end
            end

            ST_CAPTURE: begin
               if (r_vs_rise) begin
                  r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                  if (!i_mode_cont) begin
                     r_state  <= ST_HOLD;
                     r_cap_en <= 1'b0;
                  end
               end
            end

            // a frame edge coinciding with the request is not used to start capture
            ST_HOLD: begin
               if (i_snap_req || i_mode_cont) begin
                  r_state <= ST_ARM;
               end
            end

            ST_ARM: begin
               if (r_vs_rise) begin
                  r_state  <= ST_CAPTURE;
                  r_cap_en <= 1'b1;
               end
            end

            ST_FAIL: begin
               r_cap_en <= 1'b0;
            end

            default: begin
               r_state     <= ST_FAIL;
               r_cap_en    <= 1'b0;
               r_busy      <= 1'b0;
               r_init_fail <= 1'b1;
            end
         endcase
      end
   end

   assign o_cam_start = r_cam_start;
   assign o_cap_en    = r_cap_en;
   assign o_frame_cnt = r_frame_cnt;
   assign o_busy      = r_busy;
   assign o_init_fail = r_init_fail;
   assign o_state     = r_state;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_frame_capture_ctrl
//  Directed bench for frame_capture_ctrl with small timing parameters.
//  Expected o_cam_start cycles and o_frame_cnt values are queued as stimulus is
//  applied and compared by a monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_frame_capture_ctrl;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             auto_start;
   logic             cam_start;
   logic             cam_done;
   logic             vsync;
   logic             mode_cont;
   logic             snap_req;
   logic             cap_en;
   logic [CNT_W-1:0] frame_cnt;
   logic             busy;
   logic             init_fail;
   logic [2:0]       state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rel_base = 0;
   int n_pulses = 0;

   int               exp_start_q[$];
   logic [CNT_W-1:0] exp_fc_q[$];
   logic [CNT_W-1:0] prev_fc = '0;

   frame_capture_ctrl #(
      .PWRUP_DELAY_CYC (10),
      .INIT_TIMEOUT_CYC(100),
      .MAX_RETRIES     (2),
      .CNT_W           (CNT_W)
   ) dut (
      .i_top_clk    (clk),
      .w_rst_btn_db (rst_n),
      .i_auto_start (auto_start),
      .o_cam_start  (cam_start),
      .i_cam_done   (cam_done),
      .i_vsync_async(vsync),
      .i_mode_cont  (mode_cont),
      .i_snap_req   (snap_req),
      .o_cap_en     (cap_en),
      .o_frame_cnt  (frame_cnt),
      .o_busy       (busy),
      .o_init_fail  (init_fail),
      .o_state      (state)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard side: compare start pulses and frame counter updates
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_fc <= '0;
      end else begin
         if (cam_start === 1'b1) begin
            n_pulses <= n_pulses + 1;
            if (exp_start_q.size() == 0) chk("cam_start_unexpected", 32'(cam_start), 32'd0);
            else chk("cam_start_cycle", 32'(cyc - rel_base), 32'(exp_start_q.pop_front()));
         end
         if (frame_cnt !== prev_fc) begin
            if (exp_fc_q.size() == 0) chk("frame_cnt_unexpected", 32'(frame_cnt), 32'(prev_fc));
            else chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc_q.pop_front()));
         end
         prev_fc <= frame_cnt;
      end
   end

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int i = 0;
      while (state !== s && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(tag, 32'(state), 32'(s));
   endtask

   task automatic vs_pulse();
      @(negedge clk) vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic snap_pulse();
      @(negedge clk) snap_req = 1'b1;
      @(negedge clk) snap_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset(input logic auto_lvl);
      @(negedge clk);
      rst_n      = 1'b0;
      auto_start = auto_lvl;
      cam_done   = 1'b0;
      vsync      = 1'b0;
      snap_req   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_cap_en", 32'(cap_en), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_init_fail", 32'(init_fail), 32'd0);
      chk("rst_cam_start", 32'(cam_start), 32'd0);
   endtask

   // reset, init succeeds 20 cycles after start, first frame edge enters CAPTURE
   task automatic bring_up(input string tag);
      do_reset(1'b1);
      exp_start_q.push_back(11);
      rel_base = cyc;
      rst_n    = 1'b1;
      wait_state(3'd1, 50, {tag, "_cfg_start"});
      repeat (20) @(negedge clk);
      cam_done = 1'b1;
      wait_state(3'd3, 10, {tag, "_sync"});
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      chk({tag, "_sync_cap_en"}, 32'(cap_en), 32'd0);
      vs_pulse();
      chk({tag, "_capture_state"}, 32'(state), 32'd4);
      chk({tag, "_capture_cap_en"}, 32'(cap_en), 32'd1);
      chk({tag, "_capture_cnt"}, 32'(frame_cnt), 32'd0);
   endtask

   initial begin
      int np0;
      int r;
      rst_n      = 1'b0;
      auto_start = 1'b0;
      cam_done   = 1'b0;
      vsync      = 1'b0;
      mode_cont  = 1'b1;
      snap_req   = 1'b0;

      // 1: normal bring-up in continuous mode
      bring_up("t1");

      // 3: continuous counting and wrap
      for (int k = 1; k <= 5; k++) begin
         exp_fc_q.push_back(CNT_W'(k));
         vs_pulse();
      end
      chk("t3_cnt5", 32'(frame_cnt), 32'd5);
      chk("t3_cap_en", 32'(cap_en), 32'd1);
      for (int k = 6; k <= 21; k++) begin
         exp_fc_q.push_back(CNT_W'(k));
         vs_pulse();
      end
      chk("t3_wrap_cnt", 32'(frame_cnt), 32'd5);
      chk("t3_wrap_state", 32'(state), 32'd4);

      // 2: init never completes; also hold auto_start low past the power-up delay
      do_reset(1'b0);
      np0      = n_pulses;
      rel_base = cyc;
      rst_n    = 1'b1;
      repeat (30) @(negedge clk);
      chk("t2_wait_auto_state", 32'(state), 32'd0);
      chk("t2_wait_auto_pulses", 32'(n_pulses - np0), 32'd0);
      r = cyc - rel_base;
      exp_start_q.push_back(r + 1);
      exp_start_q.push_back(r + 102);
      auto_start = 1'b1;
      wait_state(3'd7, 400, "t2_fail_state");
      chk("t2_init_fail", 32'(init_fail), 32'd1);
      chk("t2_cap_en", 32'(cap_en), 32'd0);
      chk("t2_busy", 32'(busy), 32'd0);
      vs_pulse();
      snap_pulse();
      mode_cont = 1'b0;
      vs_pulse();
      mode_cont = 1'b1;
      chk("t2_still_fail", 32'(state), 32'd7);
      chk("t2_fail_sticky", 32'(init_fail), 32'd1);
      chk("t2_cap_en_after", 32'(cap_en), 32'd0);
      chk("t2_pulse_count", 32'(n_pulses - np0), 32'd2);

      // 4: snapshot mode
      mode_cont = 1'b0;
      bring_up("t4");
      exp_fc_q.push_back(CNT_W'(1));
      vs_pulse();
      chk("t4_hold_cnt", 32'(frame_cnt), 32'd1);
      chk("t4_hold_cap_en", 32'(cap_en), 32'd0);
      chk("t4_hold_state", 32'(state), 32'd5);
      for (int k = 0; k < 10; k++) vs_pulse();
      chk("t4_frozen_cnt", 32'(frame_cnt), 32'd1);
      chk("t4_frozen_state", 32'(state), 32'd5);
      snap_pulse();
      chk("t4_arm_state", 32'(state), 32'd6);
      chk("t4_arm_cap_en", 32'(cap_en), 32'd0);
      vs_pulse();
      chk("t4_recap_cap_en", 32'(cap_en), 32'd1);
      chk("t4_recap_state", 32'(state), 32'd4);
      exp_fc_q.push_back(CNT_W'(2));
      vs_pulse();
      chk("t4_done_cap_en", 32'(cap_en), 32'd0);
      chk("t4_done_cnt", 32'(frame_cnt), 32'd2);

      // 5: snap request on the same cycle as the frame edge in HOLD
      @(negedge clk) vsync = 1'b1;
      repeat (3) @(negedge clk);
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      vsync    = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5_arm_state", 32'(state), 32'd6);
      chk("t5_arm_cap_en", 32'(cap_en), 32'd0);
      vs_pulse();
      chk("t5_capture_cap_en", 32'(cap_en), 32'd1);
      // snap request while capturing is dropped, not queued
      snap_pulse();
      exp_fc_q.push_back(CNT_W'(3));
      vs_pulse();
      chk("t5_hold_state", 32'(state), 32'd5);
      vs_pulse();
      vs_pulse();
      chk("t5_no_queued_snap", 32'(state), 32'd5);
      chk("t5_no_queued_cap_en", 32'(cap_en), 32'd0);

      // 6: reset in the middle of CAPTURE
      mode_cont = 1'b1;
      bring_up("t6a");
      exp_fc_q.push_back(CNT_W'(1));
      vs_pulse();
      exp_fc_q.push_back(CNT_W'(2));
      vs_pulse();
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_cap_en", 32'(cap_en), 32'd0);
      chk("t6_async_cnt", 32'(frame_cnt), 32'd0);
      chk("t6_async_state", 32'(state), 32'd0);
      bring_up("t6b");

      repeat (5) @(negedge clk);
      chk("end_start_q_empty", 32'(exp_start_q.size()), 32'd0);
      chk("end_fc_q_empty", 32'(exp_fc_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
